// File: rtl/sobel_stream_filter.sv
// sobel_stream_filter
//   Streaming 3x3 Sobel edge filter. Accepts one grayscale pixel per cycle in
//   raster order, keeps two image lines plus a 3x3 window, and emits one
//   output pixel per input pixel (passthrough, |Gx|+|Gy| magnitude, binary
//   threshold or inverted binary). The threshold is stepped up/down at run time
//   from two button levels.
//
//   Handshakes: a transfer happens on a rising edge of sobel_clk when both
//   valid and ready are high on that edge. out_valid/out_px/out_eof are held
//   stable while out_valid=1 and out_ready=0. in_ready never depends on
//   in_valid.
//
// Ports
//   sobel_clk        single clock, rising edge
//   reset            synchronous, active-low
//   in_valid/in_ready/in_px      input pixel stream
//   out_valid/out_ready/out_px   output pixel stream
//   out_eof          high with the last output pixel of a frame
//   mode             0 passthrough, 1 magnitude, 2 binary, 3 inverted binary
//   threshold_up/_down button levels, each rising edge steps the threshold
//   threshold        current threshold
//   dbg_state        current FSM state (0 FILL, 1 RUN, 2 FLUSH)
module sobel_stream_filter #(
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240,
  parameter int PX_W     = 8,
  parameter int THR_INIT = 128,
  parameter int THR_STEP = 4
) (
  input  logic            sobel_clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PX_W-1:0] in_px,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PX_W-1:0] out_px,
  output logic            out_eof,
  input  logic [1:0]      mode,
  input  logic            threshold_up,
  input  logic            threshold_down,
  output logic [PX_W-1:0] threshold,
  output logic [1:0]      dbg_state
);

  localparam int COL_W = $clog2(IMG_W);
  // Row counter must reach IMG_H while the flush steps walk past the frame.
  localparam int ROW_W = $clog2(IMG_H + 2);

  localparam logic [COL_W-1:0] COL_LAST    = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] COL_ONE     = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] ROW_ONE     = ROW_W'(1);
  localparam logic [PX_W-1:0]  PX_MAX      = {PX_W{1'b1}};
  localparam logic [PX_W-1:0]  THR_STEP_PX = PX_W'(THR_STEP);
  localparam logic [PX_W-1:0]  THR_RST     = PX_W'(THR_INIT);
  localparam logic [PX_W+3:0]  MAG_MAX     = {4'b0000, PX_MAX};

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [COL_W-1:0] in_col_q, in_col_d;
  logic [ROW_W-1:0] in_row_q, in_row_d;
  logic [COL_W-1:0] o_col_q, o_col_d;
  logic [ROW_W-1:0] o_row_q, o_row_d;
  logic [PX_W-1:0]  win_q [3][3];
  logic [PX_W-1:0]  win_d [3][3];
  logic             out_valid_q, out_valid_d;
  logic [PX_W-1:0]  out_px_q, out_px_d;
  logic             out_eof_q, out_eof_d;
  logic [PX_W-1:0]  thr_q, thr_d;
  logic             up_s_q, up_d_q, dn_s_q, dn_d_q;

  // lb0 holds the previous line, lb1 the line before that (indexed by column).
  logic [PX_W-1:0]  lb0_q [IMG_W];
  logic [PX_W-1:0]  lb1_q [IMG_W];

  logic             slot_free, accept, flush_step, step, emit;
  logic [PX_W-1:0]  col_new [3];
  logic [PX_W+2:0]  sx_r, sx_l, sy_b, sy_t, gx, gy, abs_x, abs_y;
  logic [PX_W+3:0]  mag;
  logic [PX_W-1:0]  mag_sat, bin_px, result;
  logic             border, last_in, fill_done, eof_now, up_edge, dn_edge;

  always_comb begin
    slot_free  = !out_valid_q || out_ready;
    case (state_q)
      S_FILL:  in_ready = 1'b1;
      S_RUN:   in_ready = slot_free;
      default: in_ready = 1'b0;
    endcase
    accept     = in_valid && in_ready;
    flush_step = (state_q == S_FLUSH) && slot_free;
    step       = accept || flush_step;
    emit       = (accept && (state_q == S_RUN)) || flush_step;

    // New window column: two lines up, one line up, current pixel (zero
    // below the frame while flushing).
    col_new[0] = lb1_q[in_col_q];
    col_new[1] = lb0_q[in_col_q];
    col_new[2] = (state_q == S_FLUSH) ? '0 : in_px;

    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_d[r][c] = win_q[r][c];
      end
      if (step) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
        win_d[r][2] = col_new[r];
      end
    end

    // Gradient on the window as it will be after this step.
    sx_r  = {3'b000, win_d[0][2]} + {2'b00, win_d[1][2], 1'b0} + {3'b000, win_d[2][2]};
    sx_l  = {3'b000, win_d[0][0]} + {2'b00, win_d[1][0], 1'b0} + {3'b000, win_d[2][0]};
    sy_b  = {3'b000, win_d[2][0]} + {2'b00, win_d[2][1], 1'b0} + {3'b000, win_d[2][2]};
    sy_t  = {3'b000, win_d[0][0]} + {2'b00, win_d[0][1], 1'b0} + {3'b000, win_d[0][2]};
    gx    = sx_r - sx_l;
    gy    = sy_b - sy_t;
    abs_x = gx[PX_W+2] ? -gx : gx;
    abs_y = gy[PX_W+2] ? -gy : gy;
    mag   = {1'b0, abs_x} + {1'b0, abs_y};
    mag_sat = (mag > MAG_MAX) ? PX_MAX : mag[PX_W-1:0];
    bin_px  = (mag_sat >= thr_q) ? PX_MAX : '0;

    // The output counters track the window centre, not the input pixel.
    border  = (o_row_q == '0) || (o_row_q == ROW_LAST) ||
              (o_col_q == '0) || (o_col_q == COL_LAST);
    eof_now = (o_row_q == ROW_LAST) && (o_col_q == COL_LAST);

    case (mode)
      2'd0:    result = win_d[1][1];
      2'd1:    result = border ? '0 : mag_sat;
      2'd2:    result = border ? '0 : bin_px;
      default: result = border ? '0 : ~bin_px;
    endcase

    last_in   = (in_row_q == ROW_LAST) && (in_col_q == COL_LAST);
    fill_done = (in_row_q == ROW_ONE) && (in_col_q == '0);

    in_col_d = in_col_q;
    in_row_d = in_row_q;
    if (step) begin
      if (in_col_q == COL_LAST) begin
        in_col_d = '0;
        in_row_d = in_row_q + ROW_ONE;
      end else begin
        in_col_d = in_col_q + COL_ONE;
      end
    end

    o_col_d = o_col_q;
    o_row_d = o_row_q;
    if (emit) begin
      if (o_col_q == COL_LAST) begin
        o_col_d = '0;
        o_row_d = o_row_q + ROW_ONE;
      end else begin
        o_col_d = o_col_q + COL_ONE;
      end
    end

    state_d = state_q;
    case (state_q)
      S_FILL:  if (accept && fill_done) state_d = S_RUN;
      S_RUN:   if (accept && last_in) state_d = S_FLUSH;
      default: begin
        // Leave FLUSH as soon as the eof pixel is registered, so pixel 0 of
        // the next frame can be accepted while that pixel is handed off.
        if (flush_step && eof_now) begin
          state_d  = S_FILL;
          in_col_d = '0;
          in_row_d = '0;
          o_col_d  = '0;
          o_row_d  = '0;
        end
      end
    endcase

    out_valid_d = out_valid_q;
    out_px_d    = out_px_q;
    out_eof_d   = out_eof_q;
    if (emit) begin
      out_valid_d = 1'b1;
      out_px_d    = result;
      out_eof_d   = eof_now;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_eof_d   = 1'b0;
    end

    up_edge = up_s_q && !up_d_q;
    dn_edge = dn_s_q && !dn_d_q;
    thr_d   = thr_q;
    if (up_edge && !dn_edge) begin
      thr_d = (thr_q > PX_MAX - THR_STEP_PX) ? PX_MAX : thr_q + THR_STEP_PX;
    end else if (dn_edge && !up_edge) begin
      thr_d = (thr_q < THR_STEP_PX) ? '0 : thr_q - THR_STEP_PX;
    end
  end

  always_ff @(posedge sobel_clk) begin
    if (!reset) begin
      state_q     <= S_FILL;
      in_col_q    <= '0;
      in_row_q    <= '0;
      o_col_q     <= '0;
      o_row_q     <= '0;
      out_valid_q <= 1'b0;
      out_px_q    <= '0;
      out_eof_q   <= 1'b0;
      thr_q       <= THR_RST;
      up_s_q      <= 1'b0;
      up_d_q      <= 1'b0;
      dn_s_q      <= 1'b0;
      dn_d_q      <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      in_col_q    <= in_col_d;
      in_row_q    <= in_row_d;
      o_col_q     <= o_col_d;
      o_row_q     <= o_row_d;
      out_valid_q <= out_valid_d;
      out_px_q    <= out_px_d;
      out_eof_q   <= out_eof_d;
      thr_q       <= thr_d;
      up_s_q      <= threshold_up;
      up_d_q      <= up_s_q;
      dn_s_q      <= threshold_down;
      dn_d_q      <= dn_s_q;
      win_q       <= win_d;
    end
  end

  // Line buffers carry no reset; stale contents only ever reach border
  // centres, which are forced to zero.
  always_ff @(posedge sobel_clk) begin
    if (step) begin
      lb1_q[in_col_q] <= lb0_q[in_col_q];
      lb0_q[in_col_q] <= col_new[2];
    end
  end

  assign out_valid = out_valid_q;
  assign out_px    = out_px_q;
  assign out_eof   = out_eof_q;
  assign threshold = thr_q;
  assign dbg_state = state_q;

endmodule
